// File: rtl/match_ctrl.sv
// match_ctrl: Pong match sequencer.
// Clears the score block, holds the ball through the serve countdown, enables
// play, turns ball misses into single-cycle score pulses and, on the last
// point-pause tick, reads game_over to choose between serving again and
// ending the match.
//
// Ports
//   clk, reset        system clock, synchronous active-high reset
//   start             start button level (rising edge detected internally)
//   pause             freezes play while high (PLAY only)
//   frame_tick        one-cycle pulse per video frame
//   miss_left/right   ball crossed the left/right edge
//   game_over         score block reports the match limit reached
//   score_left/right  one-cycle score increment pulses
//   score_reset       one-cycle score clear pulse
//   ball_reset        hold ball at centre
//   ball_enable       allow ball motion
//   serve_dir         0 = toward left player, 1 = toward right player
//   state             current state encoding (debug/display)
module match_ctrl #(
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned POINT_FRAMES = 30,
  parameter int unsigned CNT_W        = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       frame_tick,
  input  logic       miss_left,
  input  logic       miss_right,
  input  logic       game_over,
  output logic       score_left,
  output logic       score_right,
  output logic       score_reset,
  output logic       ball_reset,
  output logic       ball_enable,
  output logic       serve_dir,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_POINT = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [CNT_W-1:0] POINT_LAST = CNT_W'(POINT_FRAMES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           cur, nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             start_q;
  logic             start_armed;
  logic             start_edge_c;
  logic             score_left_nxt, score_right_nxt, score_reset_nxt;
  logic             ball_reset_nxt, ball_enable_nxt, serve_dir_nxt;

  // start_armed stays low after reset until start is seen low, so a button
  // held through reset cannot launch a match.
  assign start_edge_c = start & ~start_q & start_armed;
  assign state        = cur;

  // State, counter and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      cur         <= S_IDLE;
      cnt         <= '0;
      start_q     <= 1'b0;
      start_armed <= 1'b0;
      score_left  <= 1'b0;
      score_right <= 1'b0;
      score_reset <= 1'b0;
      ball_reset  <= 1'b1;
      ball_enable <= 1'b0;
      serve_dir   <= 1'b1;
    end else begin
      cur         <= nxt;
      cnt         <= cnt_nxt;
      start_q     <= start;
      start_armed <= start_armed | ~start;
      score_left  <= score_left_nxt;
      score_right <= score_right_nxt;
      score_reset <= score_reset_nxt;
      ball_reset  <= ball_reset_nxt;
      ball_enable <= ball_enable_nxt;
      serve_dir   <= serve_dir_nxt;
    end
  end

  // Next state, counter and output values
  always_comb begin
    nxt             = cur;
    cnt_nxt         = cnt;
    score_left_nxt  = 1'b0;
    score_right_nxt = 1'b0;
    score_reset_nxt = 1'b0;
    serve_dir_nxt   = serve_dir;

    unique case (cur)
      S_IDLE, S_OVER: begin
        if (start_edge_c) begin
          score_reset_nxt = 1'b1;
          serve_dir_nxt   = 1'b1;
          cnt_nxt         = '0;
          nxt             = S_SERVE;
        end
      end
      S_SERVE: begin
        if (frame_tick) begin
          if (cnt == SERVE_LAST) nxt = S_PLAY;
          else                   cnt_nxt = cnt + CNT_ONE;
        end
      end
      S_PLAY: begin
        // miss_left has priority when both edges are crossed together
        if (!pause) begin
          if (miss_left) begin
            score_right_nxt = 1'b1;
            serve_dir_nxt   = 1'b0;
            cnt_nxt         = '0;
            nxt             = S_POINT;
          end else if (miss_right) begin
            score_left_nxt  = 1'b1;
            serve_dir_nxt   = 1'b1;
            cnt_nxt         = '0;
            nxt             = S_POINT;
          end
        end
      end
      S_POINT: begin
        if (frame_tick) begin
          if (cnt == POINT_LAST) begin
            if (game_over) begin
              nxt = S_OVER;
            end else begin
              cnt_nxt = '0;
              nxt     = S_SERVE;
            end
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end
      end
      default: begin
        cnt_nxt = '0;
        nxt     = S_IDLE;
      end
    endcase

    // Ball controls follow the state being entered so they line up with it
    ball_reset_nxt  = (nxt != S_PLAY);
    ball_enable_nxt = (nxt == S_PLAY) & ~pause;
  end

endmodule

// File: tb/tb_match_ctrl.sv
// Testbench for match_ctrl: directed scenarios with literal expectations,
// then randomized traffic checked against a countdown-based match model.
module tb_match_ctrl;

  localparam int SERVE = 3;
  localparam int POINT = 2;

  logic       clk = 1'b0;
  logic       reset, start, pause, frame_tick, miss_left, miss_right, game_over;
  logic       score_left, score_right, score_reset, ball_reset, ball_enable, serve_dir;
  logic [2:0] state;

  int errors = 0;
  int checks = 0;

  // Reference model: match phase plus frames remaining in the current wait
  int   m_phase;
  int   m_remain;
  bit   m_prev, m_armed;
  bit   m_sl, m_sr, m_sre, m_br, m_be, m_dir;

  match_ctrl #(.SERVE_FRAMES(SERVE), .POINT_FRAMES(POINT), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause),
    .frame_tick(frame_tick), .miss_left(miss_left), .miss_right(miss_right),
    .game_over(game_over), .score_left(score_left), .score_right(score_right),
    .score_reset(score_reset), .ball_reset(ball_reset), .ball_enable(ball_enable),
    .serve_dir(serve_dir), .state(state)
  );

  always #5 clk = ~clk;

  task automatic model_update();
    bit edge_seen;
    edge_seen = start && !m_prev && m_armed;
    m_sl = 0; m_sr = 0; m_sre = 0;
    if (reset) begin
      m_phase = 0; m_remain = 0; m_prev = 0; m_armed = 0;
      m_dir = 1; m_br = 1; m_be = 0;
    end else begin
      case (m_phase)
        0, 4: if (edge_seen) begin
          m_sre = 1; m_dir = 1; m_phase = 1; m_remain = SERVE;
        end
        1: if (frame_tick) begin
          m_remain--;
          if (m_remain == 0) m_phase = 2;
        end
        2: if (!pause) begin
          if (miss_left) begin
            m_sr = 1; m_dir = 0; m_phase = 3; m_remain = POINT;
          end else if (miss_right) begin
            m_sl = 1; m_dir = 1; m_phase = 3; m_remain = POINT;
          end
        end
        3: if (frame_tick) begin
          m_remain--;
          if (m_remain == 0) begin
            if (game_over) m_phase = 4;
            else begin m_phase = 1; m_remain = SERVE; end
          end
        end
        default: m_phase = 0;
      endcase
      m_prev  = start;
      m_armed = m_armed | !start;
      m_br    = (m_phase != 2);
      m_be    = (m_phase == 2) && !pause;
    end
  endtask

  // One clock: model follows the DUT's sampled inputs, outputs read 1 ns later
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic tick_once();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1; start = 0; pause = 0; frame_tick = 0;
    miss_left = 0; miss_right = 0; game_over = 0;
    step(); step();
    checks++;
    if (state !== 3'd0 || ball_reset !== 1'b1 || ball_enable !== 1'b0 || serve_dir !== 1'b1 ||
        score_left !== 1'b0 || score_right !== 1'b0 || score_reset !== 1'b0) begin
      errors++;
      $display("FAIL reset: state=%0d br=%b be=%b dir=%b sl=%b sr=%b sre=%b, want 0 1 0 1 0 0 0",
               state, ball_reset, ball_enable, serve_dir, score_left, score_right, score_reset);
    end
    reset = 0;
    step();
  endtask

  task automatic test_serve();
    start = 1;
    step();
    checks++;
    if (state !== 3'd1 || score_reset !== 1'b1) begin
      errors++;
      $display("FAIL serve_start: state=%0d score_reset=%b, want 1 1", state, score_reset);
    end
    step();
    checks++;
    if (score_reset !== 1'b0) begin
      errors++;
      $display("FAIL score_reset_width: got %b want 0", score_reset);
    end
    tick_once(); tick_once();
    checks++;
    if (state !== 3'd1) begin
      errors++;
      $display("FAIL serve_hold: state=%0d want 1", state);
    end
    tick_once();
    checks++;
    if (state !== 3'd2 || ball_enable !== 1'b1 || ball_reset !== 1'b0) begin
      errors++;
      $display("FAIL serve_to_play: state=%0d be=%b br=%b, want 2 1 0", state, ball_enable, ball_reset);
    end
  endtask

  task automatic test_miss_left();
    miss_left = 1;
    step();
    miss_left = 0;
    checks++;
    if (score_right !== 1'b1 || score_left !== 1'b0 || state !== 3'd3 || serve_dir !== 1'b0) begin
      errors++;
      $display("FAIL miss_left: sr=%b sl=%b state=%0d dir=%b, want 1 0 3 0",
               score_right, score_left, state, serve_dir);
    end
    step();
    checks++;
    if (score_right !== 1'b0) begin
      errors++;
      $display("FAIL score_right_width: got %b want 0", score_right);
    end
    game_over = 0;
    tick_once();
    checks++;
    if (state !== 3'd3) begin
      errors++;
      $display("FAIL point_hold: state=%0d want 3", state);
    end
    tick_once();
    checks++;
    if (state !== 3'd1) begin
      errors++;
      $display("FAIL point_to_serve: state=%0d want 1", state);
    end
    repeat (SERVE) tick_once();
  endtask

  task automatic test_both_miss();
    miss_left = 1; miss_right = 1;
    step();
    miss_left = 0; miss_right = 0;
    checks++;
    if (score_right !== 1'b1 || score_left !== 1'b0 || serve_dir !== 1'b0) begin
      errors++;
      $display("FAIL both_miss: sr=%b sl=%b dir=%b, want 1 0 0", score_right, score_left, serve_dir);
    end
    step();
    checks++;
    if (score_right !== 1'b0 || score_left !== 1'b0) begin
      errors++;
      $display("FAIL both_miss_after: sr=%b sl=%b, want 0 0", score_right, score_left);
    end
    repeat (POINT + SERVE) tick_once();
  endtask

  task automatic test_pause();
    checks++;
    if (state !== 3'd2) begin
      errors++;
      $display("FAIL pause_entry: state=%0d want 2", state);
    end
    pause = 1; miss_right = 1;
    for (int i = 0; i < 5; i++) begin
      tick_once();
      checks++;
      if (ball_enable !== 1'b0 || score_left !== 1'b0 || score_right !== 1'b0 || state !== 3'd2) begin
        errors++;
        $display("FAIL pause_hold[%0d]: be=%b sl=%b sr=%b state=%0d, want 0 0 0 2",
                 i, ball_enable, score_left, score_right, state);
      end
    end
    pause = 0; miss_right = 0;
    step();
    checks++;
    if (ball_enable !== 1'b1) begin
      errors++;
      $display("FAIL unpause: be=%b want 1", ball_enable);
    end
    miss_right = 1;
    step();
    miss_right = 0;
    checks++;
    if (score_left !== 1'b1 || score_right !== 1'b0 || serve_dir !== 1'b1 || state !== 3'd3) begin
      errors++;
      $display("FAIL miss_right: sl=%b sr=%b dir=%b state=%0d, want 1 0 1 3",
               score_left, score_right, serve_dir, state);
    end
  endtask

  task automatic test_game_over();
    game_over = 1;
    tick_once(); tick_once();
    checks++;
    if (state !== 3'd4 || ball_reset !== 1'b1) begin
      errors++;
      $display("FAIL game_over: state=%0d br=%b, want 4 1", state, ball_reset);
    end
    miss_left = 1;
    step();
    miss_left = 0;
    checks++;
    if (score_left !== 1'b0 || score_right !== 1'b0 || state !== 3'd4) begin
      errors++;
      $display("FAIL over_miss: sl=%b sr=%b state=%0d, want 0 0 4", score_left, score_right, state);
    end
    game_over = 0;
    start = 0;
    step();
    start = 1;
    step();
    checks++;
    if (score_reset !== 1'b1 || state !== 3'd1 || serve_dir !== 1'b1) begin
      errors++;
      $display("FAIL restart: sre=%b state=%0d dir=%b, want 1 1 1", score_reset, state, serve_dir);
    end
  endtask

  task automatic test_reset_mid_serve();
    tick_once();
    reset = 1;
    step();
    checks++;
    if (state !== 3'd0 || ball_reset !== 1'b1 || score_reset !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_serve: state=%0d br=%b sre=%b, want 0 1 0", state, ball_reset, score_reset);
    end
    reset = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (state !== 3'd0 || score_reset !== 1'b0) begin
        errors++;
        $display("FAIL start_held[%0d]: state=%0d sre=%b, want 0 0", i, state, score_reset);
      end
    end
    start = 0;
    step();
    start = 1;
    step();
    checks++;
    if (state !== 3'd1 || score_reset !== 1'b1) begin
      errors++;
      $display("FAIL new_edge: state=%0d sre=%b, want 1 1", state, score_reset);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      reset      = ($urandom % 150) == 0;
      if (($urandom % 6) == 0) start = ~start;
      pause      = ($urandom % 8) == 0;
      frame_tick = ($urandom % 3) == 0;
      miss_left  = ($urandom % 12) == 0;
      miss_right = ($urandom % 12) == 0;
      game_over  = ($urandom % 3) == 0;
      step();
      checks++;
      if (state !== 3'(m_phase) || score_left !== m_sl || score_right !== m_sr ||
          score_reset !== m_sre || ball_reset !== m_br || ball_enable !== m_be ||
          serve_dir !== m_dir) begin
        errors++;
        $display("FAIL random[%0d]: state/sl/sr/sre/br/be/dir got %0d %b %b %b %b %b %b want %0d %b %b %b %b %b %b",
                 c, state, score_left, score_right, score_reset, ball_reset, ball_enable, serve_dir,
                 m_phase, m_sl, m_sr, m_sre, m_br, m_be, m_dir);
      end
    end
  endtask

  initial begin
    test_reset();
    test_serve();
    test_miss_left();
    test_both_miss();
    test_pause();
    test_game_over();
    test_reset_mid_serve();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
